// File: rtl/directory_tag_update.sv
// 8-way directory tag lookup / allocate / invalidate with round-robin victim.
// Ports: req_* handshake in, tag_lines_in from store, *_wb write-back, resp_*.
module directory_tag_update #(
  parameter int TAG_SIZE = 18,
  parameter int IDX_CNT  = 512,
  localparam int IW      = $clog2(IDX_CNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [IW-1:0]         req_idx,
  input  logic [TAG_SIZE-1:0]   req_tag,
  input  logic [TAG_SIZE*8-1:0] tag_lines_in,
  output logic [TAG_SIZE*8-1:0] tag_out_wb,
  output logic [IW-1:0]         idx_out_wb,
  output logic                  alloc,
  output logic                  st_fwd,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [2:0]            resp_way,
  output logic                  victim_valid,
  output logic [TAG_SIZE-1:0]   victim_tag
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    UPDATE
  } state_t;

  state_t state, state_nx;

  logic [7:0] valid_mem [IDX_CNT];
  logic [2:0] ptr_mem   [IDX_CNT];

  logic [2:0]          op_q;
  logic [IW-1:0]       idx_q;
  logic [TAG_SIZE-1:0] tag_q;
  logic                fwd_q;
  logic [7:0]          pend_valid;
  logic [2:0]          pend_ptr;

  logic accept;

  assign req_ready = ~rst & (state != LOOKUP);
  assign accept    = req_valid & req_ready
                   & (req_op != 3'd0);
  assign st_fwd    = (state == UPDATE) & accept
                   & alloc & (req_idx == idx_out_wb);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = LOOKUP;
      LOOKUP:  state_nx = UPDATE;
      UPDATE:  state_nx = accept ? LOOKUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic                  is_alloc;
  logic                  is_inval;
  logic [TAG_SIZE*8-1:0] line;
  logic [7:0]            vbits;
  logic [2:0]            cur_ptr;
  logic [7:0]            hit_vec;
  logic                  hit;
  logic [2:0]            hit_way;
  logic                  has_inv;
  logic [2:0]            inv_way;
  logic [2:0]            vict;
  logic [2:0]            way;
  logic [TAG_SIZE*8-1:0] new_line;
  logic [7:0]            new_valid;
  logic [2:0]            new_ptr;
  logic                  do_wr;
  logic                  evict;
  logic [TAG_SIZE-1:0]   old_tag;

  always_comb begin
    is_alloc = (op_q == 3'd2);
    is_inval = (op_q == 3'd3);
    // A forwarded request sees the line the store is writing, not the
    // stale copy it read.
    line     = fwd_q ? tag_out_wb : tag_lines_in;
    vbits    = valid_mem[idx_q];
    cur_ptr  = ptr_mem[idx_q];
    hit_vec  = '0;
    hit_way  = '0;
    inv_way  = '0;
    for (int w = 0; w < 8; w++) begin
      hit_vec[w] = vbits[w]
        & (line[w*TAG_SIZE +: TAG_SIZE] == tag_q);
    end
    for (int w = 7; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 3'(w);
      if (!vbits[w])  inv_way = 3'(w);
    end
    hit       = |hit_vec;
    has_inv   = ~&vbits;
    vict      = has_inv ? inv_way : cur_ptr;
    way       = hit ? hit_way : vict;
    old_tag   = line[vict*TAG_SIZE +: TAG_SIZE];
    new_line  = line;
    new_valid = vbits;
    new_ptr   = cur_ptr;
    do_wr     = 1'b0;
    evict     = 1'b0;
    if (is_alloc && !hit) begin
      new_line[vict*TAG_SIZE +: TAG_SIZE] = tag_q;
      new_valid[vict] = 1'b1;
      do_wr = 1'b1;
      evict = ~has_inv;
      if (!has_inv) new_ptr = cur_ptr + 3'd1;
    end
    if (is_inval && hit) begin
      new_line[hit_way*TAG_SIZE +: TAG_SIZE] = '0;
      new_valid[hit_way] = 1'b0;
      do_wr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      fwd_q        <= 1'b0;
      pend_valid   <= '0;
      pend_ptr     <= '0;
      tag_out_wb   <= '0;
      idx_out_wb   <= '0;
      alloc        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      victim_valid <= 1'b0;
      victim_tag   <= '0;
      for (int i = 0; i < IDX_CNT; i++) begin
        valid_mem[i] <= '0;
        ptr_mem[i]   <= '0;
      end
    end else begin
      resp_valid   <= 1'b0;
      alloc        <= 1'b0;
      victim_valid <= 1'b0;
      if (accept) begin
        op_q  <= req_op;
        idx_q <= req_idx;
        tag_q <= req_tag;
        fwd_q <= st_fwd;
      end
      if (state == LOOKUP) begin
        resp_valid   <= 1'b1;
        resp_hit     <= hit;
        resp_way     <= way;
        alloc        <= do_wr;
        victim_valid <= evict;
        pend_valid   <= new_valid;
        pend_ptr     <= new_ptr;
        if (is_alloc && !hit) victim_tag <= old_tag;
        if (do_wr) begin
          tag_out_wb <= new_line;
          idx_out_wb <= idx_q;
        end
      end
      // Commit at the end of UPDATE so a same-set request accepted now
      // reads the new bits in its LOOKUP.
      if (state == UPDATE) begin
        valid_mem[idx_q] <= pend_valid;
        ptr_mem[idx_q]   <= pend_ptr;
      end
    end
  end

endmodule

// File: tb/tb_directory_tag_update.sv
// Randomized + directed bench for directory_tag_update with a set-level
// reference model and a behavioural tag store (read at accept, write on alloc).
module tb_directory_tag_update;

  localparam int TS  = 18;
  localparam int IDX = 512;
  localparam int IW  = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [IW-1:0] req_idx;
  logic [TS-1:0] req_tag;
  logic [TS*8-1:0] tag_lines_in;
  logic [TS*8-1:0] tag_out_wb;
  logic [IW-1:0] idx_out_wb;
  logic          alloc;
  logic          st_fwd;
  logic          resp_valid;
  logic          resp_hit;
  logic [2:0]    resp_way;
  logic          victim_valid;
  logic [TS-1:0] victim_tag;

  directory_tag_update #(.TAG_SIZE(TS), .IDX_CNT(IDX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx), .req_tag(req_tag),
    .tag_lines_in(tag_lines_in),
    .tag_out_wb(tag_out_wb), .idx_out_wb(idx_out_wb),
    .alloc(alloc), .st_fwd(st_fwd),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_way(resp_way),
    .victim_valid(victim_valid), .victim_tag(victim_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [TS*8-1:0] seed_line(int i);
    logic [TS*8-1:0] l;
    logic [31:0] v;
    for (int w = 0; w < 8; w++) begin
      v = (i * 7919 + w * 104729 + 12345) * 32'h9E3779B1;
      l[w*TS +: TS] = v[TS-1:0];
    end
    return l;
  endfunction

  // Tag store: not reset, reads old content at acceptance.
  logic [TS*8-1:0] store [IDX];
  bit              store_wr [IDX];
  logic [TS*8-1:0] rd_line = '0;
  assign tag_lines_in = rd_line;

  always @(posedge clk) begin
    if (req_valid && req_ready && req_op != 3'd0)
      rd_line <= store_wr[req_idx] ? store[req_idx]
                                   : seed_line(int'(req_idx));
    if (alloc) begin
      store[idx_out_wb]    <= tag_out_wb;
      store_wr[idx_out_wb] <= 1'b1;
    end
  end

  // Reference model
  logic [TS-1:0] m_tag [IDX][8];
  bit            m_val [IDX][8];
  int            m_ptr [IDX];
  bit            m_in_upd;
  bit            m_last_alloc;
  logic            e_hit, e_alloc, e_vv, e_fwd;
  logic [2:0]      e_way;
  logic [TS-1:0]   e_vt;
  logic [IW-1:0]   e_idxwb;
  logic [TS*8-1:0] e_line;

  int n_pass = 0;
  int n_total = 0;
  logic o_fwd, o_rdy, o_rdy_lk;

  task automatic model_reset();
    for (int i = 0; i < IDX; i++) begin
      m_ptr[i] = 0;
      for (int w = 0; w < 8; w++) m_val[i][w] = 0;
    end
    m_in_upd = 0;
    m_last_alloc = 0;
    e_idxwb = '0;
    e_line = '0;
    e_vt = '0;
  endtask

  task automatic model_step(input int op, input int idx,
                            input logic [TS-1:0] tag);
    int hw, fi, vi;
    e_fwd = m_in_upd && m_last_alloc && (idx == int'(e_idxwb));
    hw = -1;
    fi = -1;
    for (int w = 0; w < 8; w++) begin
      if (hw < 0 && m_val[idx][w] && m_tag[idx][w] == tag) hw = w;
      if (fi < 0 && !m_val[idx][w]) fi = w;
    end
    vi = (fi >= 0) ? fi : m_ptr[idx];
    e_hit = (hw >= 0);
    e_way = 3'(e_hit ? hw : vi);
    e_alloc = 0;
    e_vv = 0;
    if (op == 2 && !e_hit) begin
      e_vt = m_tag[idx][vi];
      e_vv = (fi < 0);
      m_tag[idx][vi] = tag;
      m_val[idx][vi] = 1;
      if (fi < 0) m_ptr[idx] = (m_ptr[idx] + 1) % 8;
      e_alloc = 1;
    end
    if (op == 3 && e_hit) begin
      m_tag[idx][hw] = '0;
      m_val[idx][hw] = 0;
      e_alloc = 1;
    end
    if (e_alloc) begin
      e_idxwb = IW'(idx);
      for (int w = 0; w < 8; w++) e_line[w*TS +: TS] = m_tag[idx][w];
    end
    m_last_alloc = e_alloc;
    m_in_upd = 1;
  endtask

  // Called at a negedge with the DUT in IDLE or UPDATE; returns at the
  // negedge of the response cycle.
  task automatic issue(input logic [2:0] op, input logic [IW-1:0] idx,
                       input logic [TS-1:0] tag);
    req_valid = 1'b1;
    req_op = op;
    req_idx = idx;
    req_tag = tag;
    #1;
    o_fwd = st_fwd;
    o_rdy = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'd0;
    o_rdy_lk = req_ready;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    m_in_upd = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_idx = '0;
    req_tag = '0;
    repeat (3) @(negedge clk);
    n_total++; if ({resp_valid, alloc, st_fwd, victim_valid} !== 4'b0)
      $display("FAIL rst_strobes got %b want 0000",
               {resp_valid, alloc, st_fwd, victim_valid});
    else n_pass++;
    n_total++; if ({tag_out_wb, idx_out_wb, victim_tag} !== '0)
      $display("FAIL rst_data got %h want 0",
               {tag_out_wb, idx_out_wb, victim_tag});
    else n_pass++;
    n_total++; if ({req_ready, resp_hit, resp_way} !== 5'b0)
      $display("FAIL rst_ready_resp got %b want 0",
               {req_ready, resp_hit, resp_way});
    else n_pass++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_alloc_first();
    model_step(2, 5, 18'h1234);
    issue(3'd2, 9'd5, 18'h1234);
    n_total++; if ({resp_valid, resp_hit, resp_way} !== 5'b10000)
      $display("FAIL a1_resp got %b want 10000",
               {resp_valid, resp_hit, resp_way});
    else n_pass++;
    n_total++; if ({alloc, victim_valid} !== 2'b10)
      $display("FAIL a1_alloc got %b want 10", {alloc, victim_valid});
    else n_pass++;
    n_total++; if (idx_out_wb !== 9'd5)
      $display("FAIL a1_idx got %0d want 5", idx_out_wb);
    else n_pass++;
    n_total++; if (tag_out_wb[TS-1:0] !== 18'h1234)
      $display("FAIL a1_way0 got %h want 1234", tag_out_wb[TS-1:0]);
    else n_pass++;
    n_total++; if (tag_out_wb !== e_line)
      $display("FAIL a1_line got %h want %h", tag_out_wb, e_line);
    else n_pass++;
    n_total++; if (o_rdy_lk !== 1'b0)
      $display("FAIL a1_ready_lookup got %b want 0", o_rdy_lk);
    else n_pass++;
    idle(1);
    n_total++; if ({resp_valid, alloc} !== 2'b00)
      $display("FAIL a1_strobe_drop got %b want 00", {resp_valid, alloc});
    else n_pass++;
    n_total++; if (tag_out_wb[TS-1:0] !== 18'h1234)
      $display("FAIL a1_hold got %h want 1234", tag_out_wb[TS-1:0]);
    else n_pass++;
  endtask

  task automatic test_lookup();
    model_step(1, 5, 18'h1234);
    issue(3'd1, 9'd5, 18'h1234);
    n_total++; if ({resp_hit, resp_way, alloc} !== 5'b10000)
      $display("FAIL lk_hit got %b want 10000",
               {resp_hit, resp_way, alloc});
    else n_pass++;
    model_step(5, 5, 18'h1234);
    issue(3'd5, 9'd5, 18'h1234);
    n_total++; if ({o_fwd, resp_hit, alloc} !== 3'b010)
      $display("FAIL lk_op5 got %b want 010", {o_fwd, resp_hit, alloc});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_invalidate();
    model_step(3, 5, 18'h1234);
    issue(3'd3, 9'd5, 18'h1234);
    n_total++; if ({resp_hit, resp_way, alloc} !== 5'b10001)
      $display("FAIL inv_resp got %b want 10001",
               {resp_hit, resp_way, alloc});
    else n_pass++;
    n_total++; if (tag_out_wb[TS-1:0] !== '0)
      $display("FAIL inv_way0 got %h want 0", tag_out_wb[TS-1:0]);
    else n_pass++;
    idle(1);
    model_step(1, 5, 18'h1234);
    issue(3'd1, 9'd5, 18'h1234);
    n_total++; if (resp_hit !== 1'b0)
      $display("FAIL inv_lookup got %b want 0", resp_hit);
    else n_pass++;
    model_step(3, 5, 18'h1234);
    issue(3'd3, 9'd5, 18'h1234);
    n_total++; if ({resp_hit, alloc} !== 2'b00)
      $display("FAIL inv_miss got %b want 00", {resp_hit, alloc});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_fill_evict();
    for (int k = 0; k < 8; k++) begin
      model_step(2, 7, TS'(18'h100 + k));
      issue(3'd2, 9'd7, TS'(18'h100 + k));
      n_total++; if ({resp_way, victim_valid} !== {3'(k), 1'b0})
        $display("FAIL fill_way%0d got %b want %b", k,
                 {resp_way, victim_valid}, {3'(k), 1'b0});
      else n_pass++;
      n_total++; if (o_fwd !== (k != 0))
        $display("FAIL fill_fwd%0d got %b want %b", k, o_fwd, k != 0);
      else n_pass++;
    end
    model_step(2, 7, 18'h200);
    issue(3'd2, 9'd7, 18'h200);
    n_total++; if ({resp_hit, resp_way, victim_valid, alloc} !== 6'b000011)
      $display("FAIL ev9_resp got %b want 000011",
               {resp_hit, resp_way, victim_valid, alloc});
    else n_pass++;
    n_total++; if (victim_tag !== 18'h100)
      $display("FAIL ev9_vtag got %h want 100", victim_tag);
    else n_pass++;
    model_step(2, 7, 18'h201);
    issue(3'd2, 9'd7, 18'h201);
    n_total++; if ({resp_way, victim_valid} !== 4'b0011)
      $display("FAIL ev10_resp got %b want 0011",
               {resp_way, victim_valid});
    else n_pass++;
    n_total++; if (victim_tag !== 18'h101)
      $display("FAIL ev10_vtag got %h want 101", victim_tag);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    model_step(2, 9, 18'h2abc);
    issue(3'd2, 9'd9, 18'h2abc);
    n_total++; if ({resp_hit, alloc} !== 2'b01)
      $display("FAIL b2b_first got %b want 01", {resp_hit, alloc});
    else n_pass++;
    model_step(2, 9, 18'h2abc);
    issue(3'd2, 9'd9, 18'h2abc);
    n_total++; if ({o_fwd, o_rdy} !== 2'b11)
      $display("FAIL b2b_fwd got %b want 11", {o_fwd, o_rdy});
    else n_pass++;
    n_total++; if ({resp_hit, alloc, resp_way} !== 5'b10000)
      $display("FAIL b2b_second got %b want 10000",
               {resp_hit, alloc, resp_way});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_op_none();
    req_valid = 1'b1;
    req_op = 3'd0;
    req_idx = 9'd5;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (req_ready !== 1'b1)
      $display("FAIL op0_ready got %b want 1", req_ready);
    else n_pass++;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0)
      $display("FAIL op0_resp got %b want 0", resp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    req_valid = 1'b1;
    req_op = 3'd2;
    req_idx = 9'd7;
    req_tag = 18'h3333;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if ({resp_valid, alloc, req_ready} !== 3'b000)
      $display("FAIL rstlk_strobe got %b want 000",
               {resp_valid, alloc, req_ready});
    else n_pass++;
    n_total++; if (tag_out_wb !== '0)
      $display("FAIL rstlk_wb got %h want 0", tag_out_wb);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0)
      $display("FAIL rstlk_late got %b want 0", resp_valid);
    else n_pass++;
    model_step(1, 7, 18'h107);
    issue(3'd1, 9'd7, 18'h107);
    n_total++; if ({resp_hit, resp_way} !== 4'b0000)
      $display("FAIL rstlk_miss got %b want 0000", {resp_hit, resp_way});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [IW-1:0] idx;
    logic [TS-1:0] tag;
    for (int i = 0; i < 250; i++) begin
      op  = 3'($urandom_range(1, 7));
      idx = IW'($urandom_range(20, 23));
      tag = TS'(18'h3000 + $urandom_range(0, 11));
      model_step(int'(op), int'(idx), tag);
      issue(op, idx, tag);
      n_total++; if ({resp_valid, resp_hit, resp_way} !==
                     {1'b1, e_hit, e_way})
        $display("FAIL rnd%0d_resp got %b want %b", i,
                 {resp_valid, resp_hit, resp_way}, {1'b1, e_hit, e_way});
      else n_pass++;
      n_total++; if ({alloc, victim_valid, o_fwd} !==
                     {e_alloc, e_vv, e_fwd})
        $display("FAIL rnd%0d_ctl got %b want %b", i,
                 {alloc, victim_valid, o_fwd}, {e_alloc, e_vv, e_fwd});
      else n_pass++;
      n_total++; if ({idx_out_wb, tag_out_wb, victim_tag} !==
                     {e_idxwb, e_line, e_vt})
        $display("FAIL rnd%0d_data got %h want %h", i,
                 {idx_out_wb, tag_out_wb, victim_tag},
                 {e_idxwb, e_line, e_vt});
      else n_pass++;
      if ($urandom_range(0, 2) == 0) begin
        idle(1 + $urandom_range(0, 1));
        n_total++; if ({resp_valid, alloc, victim_valid} !== 3'b000)
          $display("FAIL rnd%0d_idle got %b want 000", i,
                   {resp_valid, alloc, victim_valid});
        else n_pass++;
      end
    end
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < IDX; i++) begin
      logic [TS*8-1:0] l;
      l = seed_line(i);
      for (int w = 0; w < 8; w++) m_tag[i][w] = l[w*TS +: TS];
    end
    test_reset();
    test_alloc_first();
    test_lookup();
    test_invalidate();
    test_fill_evict();
    test_back_to_back();
    test_op_none();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/directory_tag_update.md
DIRECTORY_TAG_UPDATE -- requirements
Module: directory_tag_update

Interface
REQ-001 Parameter TAG_SIZE, default 18, tag width per way.
REQ-002 Parameter IDX_CNT, default 512, number of sets; IW = $clog2(IDX_CNT); way count fixed at 8.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block accepts request this cycle.
REQ-007 req_op  in  3  0 none, 1 lookup, 2 allocate, 3 invalidate, 4-7 treated as lookup.
REQ-008 req_idx  in  IW  set index; also drives tag store read index.
REQ-009 req_tag  in  TAG_SIZE  tag to match/install.
REQ-010 tag_lines_in  in  TAG_SIZE*8  8 way tags from tag store, valid the cycle after acceptance; way w at bits [w*TAG_SIZE +: TAG_SIZE].
REQ-011 tag_out_wb  out  TAG_SIZE*8  full updated 8-way line to tag store.
REQ-012 idx_out_wb  out  IW  set being written.
REQ-013 alloc  out  1  write tag_out_wb into idx_out_wb this cycle.
REQ-014 st_fwd  out  1  request accepted this cycle targets idx_out_wb while alloc high; store forwards tag_out_wb.
REQ-015 resp_valid  out  1  one-cycle result strobe.
REQ-016 resp_hit  out  1  tag matched a valid way.
REQ-017 resp_way  out  3  hit way, else way written/chosen.
REQ-018 victim_valid  out  1  allocate evicted a valid entry.
REQ-019 victim_tag  out  TAG_SIZE  evicted tag.

Function
REQ-020 FSM states IDLE, LOOKUP, UPDATE; one request in flight; accepted op 0 ignored (no state change).
REQ-021 req_ready = 1 in IDLE and UPDATE, 0 in LOOKUP; acceptance = req_valid & req_ready & req_op != 0.
REQ-022 IDLE/UPDATE + acceptance -> LOOKUP; request fields registered.
REQ-023 LOOKUP: per way hit = valid[idx][w] & tag match; multiple hits -> lowest way; LOOKUP -> UPDATE unconditionally.
REQ-024 Internal state: 8 valid bits and a 3-bit round-robin pointer per set, IDX_CNT entries each.
REQ-025 Victim = lowest invalid way, else way at round-robin pointer; pointer increments (mod 8) only when a valid way is replaced.
REQ-026 UPDATE outputs registered from LOOKUP: resp_valid = 1 for exactly one cycle; UPDATE with no acceptance -> IDLE.
REQ-027 Lookup: alloc = 0; resp_hit/resp_way from compare; no state change.
REQ-028 Allocate hit: alloc = 0, resp_hit = 1. Allocate miss: alloc = 1, victim way tag replaced by req_tag, other ways unchanged, valid bit set, resp_way = victim, victim_valid/victim_tag from evicted way.
REQ-029 Invalidate hit: alloc = 1, hit way tag written 0, valid cleared. Invalidate miss: alloc = 0.
REQ-030 Request-to-response latency = 2 cycles; back-to-back throughput 1 per 2 cycles.
REQ-031 st_fwd = 1 when acceptance in UPDATE, alloc = 1, req_idx == idx_out_wb; LOOKUP then compares against tag_out_wb with updated valid bits.
REQ-032 Valid-bit/pointer updates take effect at end of UPDATE, visible to a same-index request accepted in that cycle.
REQ-033 Outside UPDATE: alloc, st_fwd, resp_valid, victim_valid = 0; data outputs hold last value.

Reset
REQ-034 rst while high: FSM -> IDLE, all valid bits and pointers cleared, every output 0, any in-flight request dropped without response or write.
REQ-035 rst takes priority over every other event in the same cycle.

Verification
REQ-036 After reset, allocate idx 5 tag 0x1234 -> 2 cycles later resp_valid, resp_hit 0, resp_way 0, alloc 1, idx_out_wb 5, way0 = 0x1234, victim_valid 0.
REQ-037 Lookup idx 5 tag 0x1234 after REQ-036 -> resp_hit 1, resp_way 0, alloc 0.
REQ-038 Fill idx 7 with 8 distinct tags, then allocate ninth -> resp_way 0, victim_valid 1, victim_tag = first tag; tenth -> way 1.
REQ-039 Allocate idx 9 then allocate idx 9 same tag in UPDATE cycle -> st_fwd 1; second response resp_hit 1, alloc 0.
REQ-040 Invalidate hit idx 5 way 0 -> alloc 1, way0 tag 0; later lookup 0x1234 -> resp_hit 0.
REQ-041 rst asserted in LOOKUP -> no resp_valid/alloc; next lookup of any tag misses.
